// File: rtl/sipo_deser_hs.sv
// Serial-in/parallel-out deserialiser with a one-word holding register,
// valid/ready output handshake, selectable bit order and frame realignment.
`timescale 1ns/1ps
module sipo_deser_hs #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_ovr
);

  // Only WIDTH-1 bits are kept; the last bit comes straight from ser_in.
  logic [WIDTH-2:0] sh;
  logic [WIDTH-1:0] word;
  logic             last_bit;
  logic             complete;
  logic             load;
  logic             drop;

  always_comb begin
    word     = MSB_FIRST ? {sh, ser_in} : {ser_in, sh};
    last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    complete = ser_valid & last_bit & ~frame_sync;
    load     = complete & (~par_valid | par_ready);
    drop     = complete & par_valid & ~par_ready;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh        <= '0;
      bit_cnt   <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // On frame_sync the bit still shifts in normally: any stale bits are
      // pushed out before the next completion, so only bit_cnt must restart.
      if (ser_valid) begin
        sh <= MSB_FIRST ? word[WIDTH-2:0] : word[WIDTH-1:1];
      end

      if (frame_sync) begin
        bit_cnt <= ser_valid ? CNT_W'(1) : '0;
      end else if (ser_valid) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end

      if (load) begin
        par_out   <= word;
        par_valid <= 1'b1;
      end else if (par_valid && par_ready) begin
        par_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser_hs.sv
// Bench for sipo_deser_hs: 4-bit MSB/LSB-first and 8-bit instances, a vector
// table for the streaming/overrun sequence and hand sequences for corner cases.
`timescale 1ns/1ps
module tb_sipo_deser_hs;

  logic clk = 1'b0;
  logic rst, ser_in, ser_valid, frame_sync, par_ready, clr_ovr;

  logic [3:0] po_m, po_l;
  logic [7:0] po_w;
  logic       pv_m, pv_l, pv_w, ovr_m, ovr_l, ovr_w;
  logic [1:0] cnt_m, cnt_l;
  logic [2:0] cnt_w;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon4 = 1'b0;
  bit mon8 = 1'b0;
  logic [3:0] exp4[$];
  logic [7:0] exp8[$];

  always #5 clk = ~clk;

  sipo_deser_hs #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_sync(frame_sync),
    .par_out(po_m), .par_valid(pv_m), .par_ready(par_ready), .bit_cnt(cnt_m),
    .overrun(ovr_m), .clr_ovr(clr_ovr));

  sipo_deser_hs #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_sync(frame_sync),
    .par_out(po_l), .par_valid(pv_l), .par_ready(par_ready), .bit_cnt(cnt_l),
    .overrun(ovr_l), .clr_ovr(clr_ovr));

  sipo_deser_hs #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_w (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_sync(frame_sync),
    .par_out(po_w), .par_valid(pv_w), .par_ready(par_ready), .bit_cnt(cnt_w),
    .overrun(ovr_w), .clr_ovr(clr_ovr));

  typedef struct packed {
    logic       si, sv, fs, pr, co;
    logic [3:0] po;
    logic       pv;
    logic [1:0] cnt;
    logic       ovr;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic si, sv, fs, pr, co, input logic [3:0] po,
                              input logic pv, input logic [1:0] cnt, input logic ovr);
    return '{si, sv, fs, pr, co, po, pv, cnt, ovr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic si, input logic sv, input logic fs);
    ser_in     = si;
    ser_valid  = sv;
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    send(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // Scoreboard: a word is consumed on any edge where par_valid & par_ready.
  always @(negedge clk) begin
    if (rst && par_ready && mon4 && pv_m) begin
      if (exp4.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb4_word: got unexpected word %0h expected none", po_m);
      end else check("sb4_word", po_m, exp4.pop_front());
    end
    if (rst && par_ready && mon8 && pv_w) begin
      if (exp8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb8_word: got unexpected word %0h expected none", po_w);
      end else check("sb8_word", po_w, exp8.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wa, wb;
    rst = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; frame_sync = 1'b0;
    par_ready = 1'b0; clr_ovr = 1'b0;

    // si sv fs pr co | po pv cnt ovr
    vecs[0]  = mk(1,1,0,1,0, 4'b0000,0,1,0);
    vecs[1]  = mk(0,1,0,1,0, 4'b0000,0,2,0);
    vecs[2]  = mk(1,1,0,1,0, 4'b0000,0,3,0);
    vecs[3]  = mk(1,1,0,1,0, 4'b1011,1,0,0);
    vecs[4]  = mk(0,0,0,1,0, 4'b1011,0,0,0);
    vecs[5]  = mk(1,1,0,0,0, 4'b1011,0,1,0);
    vecs[6]  = mk(0,1,0,0,0, 4'b1011,0,2,0);
    vecs[7]  = mk(1,1,0,0,0, 4'b1011,0,3,0);
    vecs[8]  = mk(1,1,0,0,0, 4'b1011,1,0,0);
    vecs[9]  = mk(0,1,0,0,0, 4'b1011,1,1,0);
    vecs[10] = mk(1,1,0,0,0, 4'b1011,1,2,0);
    vecs[11] = mk(1,1,0,0,0, 4'b1011,1,3,0);
    vecs[12] = mk(0,1,0,0,0, 4'b1011,1,0,1);
    vecs[13] = mk(0,0,0,1,0, 4'b1011,0,0,1);
    vecs[14] = mk(0,0,0,1,1, 4'b1011,0,0,0);
    vecs[15] = mk(0,1,0,0,0, 4'b1011,0,1,0);
    vecs[16] = mk(0,1,0,0,0, 4'b1011,0,2,0);
    vecs[17] = mk(0,1,0,0,0, 4'b1011,0,3,0);
    vecs[18] = mk(1,1,0,0,0, 4'b0001,1,0,0);
    vecs[19] = mk(1,1,0,0,0, 4'b0001,1,1,0);
    vecs[20] = mk(1,1,0,0,0, 4'b0001,1,2,0);
    vecs[21] = mk(1,1,0,0,0, 4'b0001,1,3,0);
    vecs[22] = mk(1,1,0,0,1, 4'b0001,1,0,1);
    vecs[23] = mk(0,0,0,1,1, 4'b0001,0,0,0);
    vecs[24] = mk(0,0,0,1,0, 4'b0001,0,0,0);

    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("rst_po_m", po_m, 0);   check("rst_pv_m", pv_m, 0);
    check("rst_cnt_m", cnt_m, 0); check("rst_ovr_m", ovr_m, 0);
    check("rst_pv_l", pv_l, 0);   check("rst_po_w", po_w, 0);
    rst = 1'b1;
    mon4 = 1'b1;

    // Streaming, stalled overrun, clear, and set-beats-clear
    exp4.push_back(4'b1011);
    exp4.push_back(4'b1011);
    exp4.push_back(4'b0001);
    for (int i = 0; i < 25; i++) begin
      par_ready = vecs[i].pr;
      clr_ovr   = vecs[i].co;
      send(vecs[i].si, vecs[i].sv, vecs[i].fs);
      check($sformatf("row%0d_po", i), po_m, vecs[i].po);
      check($sformatf("row%0d_pv", i), pv_m, vecs[i].pv);
      check($sformatf("row%0d_cnt", i), cnt_m, vecs[i].cnt);
      check($sformatf("row%0d_ovr", i), ovr_m, vecs[i].ovr);
    end
    clr_ovr = 1'b0;

    // frame_sync realigns; partial "11" discarded
    par_ready = 1'b1;
    exp4.push_back(4'b0101);
    send(1, 1, 0); send(1, 1, 0);
    send(0, 1, 1);
    check("fs_cnt", cnt_m, 1); check("fs_pv", pv_m, 0);
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 0);
    check("fs_po", po_m, 4'b0101); check("fs_pv2", pv_m, 1);
    send(0, 0, 0);
    check("fs_drain", pv_m, 0);

    // frame_sync on the would-be last bit must not complete a word
    send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
    send(1, 1, 1);
    check("fs_last_cnt", cnt_m, 1); check("fs_last_pv", pv_m, 0);
    send(0, 0, 1);
    check("fs_idle_cnt", cnt_m, 0);
    exp4.push_back(4'b1001);
    send(1, 1, 0); send(0, 1, 0); send(0, 1, 0); send(1, 1, 0);
    check("fs_po2", po_m, 4'b1001);
    send(0, 0, 0);

    // Reset mid-word with a held word discards both
    par_ready = 1'b0;
    send(1, 1, 0); send(1, 1, 0); send(1, 1, 0); send(0, 1, 0);
    check("hold_po", po_m, 4'b1110); check("hold_pv", pv_m, 1);
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 0);
    rst = 1'b0;
    send(1, 1, 0);
    check("mrst_po", po_m, 0);   check("mrst_pv", pv_m, 0);
    check("mrst_cnt", cnt_m, 0); check("mrst_ovr", ovr_m, 0);
    rst = 1'b1;
    par_ready = 1'b1;
    exp4.push_back(4'b0011);
    send(0, 1, 0); send(0, 1, 0); send(1, 1, 0); send(1, 1, 0);
    check("post_rst_po", po_m, 4'b0011); check("post_rst_pv", pv_m, 1);
    send(0, 0, 0);

    // LSB-first with idle gaps
    do_reset();
    exp4.push_back(4'b1011);
    send(1, 1, 0); send(0, 0, 0); send(0, 0, 0);
    check("lsb_gap_cnt", cnt_l, 1); check("lsb_gap_pv", pv_l, 0);
    send(0, 1, 0); send(0, 0, 0);
    send(1, 1, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
    check("lsb_gap_cnt3", cnt_l, 3); check("lsb_gap_pv3", pv_l, 0);
    send(1, 1, 0);
    check("lsb_po", po_l, 4'b1101); check("lsb_pv", pv_l, 1); check("lsb_cnt", cnt_l, 0);
    send(0, 0, 0);

    // 8-bit: completion coincides with drain
    mon4 = 1'b0;
    do_reset();
    mon8 = 1'b1;
    wa = 8'hA5; wb = 8'h3C;
    exp8.push_back(wa);
    exp8.push_back(wb);
    par_ready = 1'b1;
    for (int i = 7; i >= 0; i--) send(wa[i], 1, 0);
    check("w8_po_a", po_w, 8'hA5); check("w8_pv_a", pv_w, 1);
    par_ready = 1'b0;
    for (int i = 7; i >= 1; i--) send(wb[i], 1, 0);
    check("w8_hold", po_w, 8'hA5);
    par_ready = 1'b1;
    send(wb[0], 1, 0);
    check("w8_po_b", po_w, 8'h3C); check("w8_pv_b", pv_w, 1); check("w8_ovr", ovr_w, 0);
    send(0, 0, 0);
    check("w8_drain", pv_w, 0);
    mon8 = 1'b0;

    check("sb4_empty", exp4.size(), 0);
    check("sb8_empty", exp8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
